// File: rtl/stepper_pkg.sv
// Shared state encoding and counter-width helper for the clock stepper.
package stepper_pkg;

   typedef enum logic [1:0] {
      ST_STEP   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } stepper_state_e;

   // Bits needed to hold counts 0..n-1 (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchroniser -> stability counter -> debounced level and one-cycle press strobe.
module button_debouncer
   import stepper_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 200_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam int unsigned CntW = cnt_w(DEBOUNCE_CYCLES);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            level_dly_q;
   logic            press_q, press_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_q & ~level_dly_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync1_q     <= btn_i;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= press_d;
         cnt_q       <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/clock_stepper.sv
// Clock-enable generator: step/run FSM with auto-run divider and halt latch.
// Optional step auto-repeat is enabled by defining STEPPER_REPEAT_EN.
module clock_stepper
   import stepper_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 200_000,
   parameter int unsigned RUN_DIV         = 1_200_000,
   parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_step_i,
   input  logic btn_run_i,
   input  logic halt_i,
   output logic clk_en_o,
   output logic run_mode_o,
   output logic halted_o
);

   localparam int unsigned DivW = cnt_w(RUN_DIV);

   stepper_state_e  state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic            div_tc;
   logic            clk_en_q, clk_en_d;
   logic            run_mode_q, halted_q;
   logic            step_press, run_press;

`ifdef STEPPER_REPEAT_EN
   localparam int unsigned RepW = cnt_w(REPEAT_CYCLES + 1);
   logic [RepW-1:0] rep_q, rep_d;
   logic            rep_on;
   logic            step_level;
`endif

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_step_i),
`ifdef STEPPER_REPEAT_EN
      .level_o (step_level),
`else
      .level_o (),
`endif
      .press_o (step_press)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_run_i),
      .level_o (),
      .press_o (run_press)
   );

   assign div_tc = (div_q == DivW'(RUN_DIV - 1));
`ifdef STEPPER_REPEAT_EN
   assign rep_on = (rep_q == RepW'(REPEAT_CYCLES));
`endif

   always_comb begin
      state_d  = state_q;
      div_d    = '0;
      clk_en_d = 1'b0;
`ifdef STEPPER_REPEAT_EN
      rep_d    = '0;
`endif
      unique case (state_q)
         ST_STEP: begin
            if (halt_i) begin
               state_d = ST_HALTED;
            end else if (run_press) begin
               state_d = ST_RUN;
            end else begin
               clk_en_d = step_press;
`ifdef STEPPER_REPEAT_EN
               // Hold counter saturates; once saturated the divider paces repeat pulses.
               if (step_level) begin
                  if (rep_on) begin
                     rep_d    = rep_q;
                     div_d    = div_tc ? '0 : div_q + 1'b1;
                     clk_en_d = step_press | div_tc;
                  end else begin
                     rep_d = rep_q + 1'b1;
                  end
               end
`endif
            end
         end
         ST_RUN: begin
            if (halt_i) begin
               state_d = ST_HALTED;
            end else if (run_press) begin
               state_d = ST_STEP;
            end else begin
               div_d    = div_tc ? '0 : div_q + 1'b1;
               clk_en_d = div_tc;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_STEP;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_STEP;
         div_q      <= '0;
         clk_en_q   <= 1'b0;
         run_mode_q <= 1'b0;
         halted_q   <= 1'b0;
`ifdef STEPPER_REPEAT_EN
         rep_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         clk_en_q   <= clk_en_d;
         run_mode_q <= (state_d == ST_RUN);
         halted_q   <= (state_d == ST_HALTED);
`ifdef STEPPER_REPEAT_EN
         rep_q      <= rep_d;
`endif
      end
   end

   assign clk_en_o   = clk_en_q;
   assign run_mode_o = run_mode_q;
   assign halted_o   = halted_q;

endmodule
